uart_host_ctrl: RTL and testbench
=================================

UART_HOST_CTRL -- requirements
Module: uart_host_ctrl

Interface
REQ-001 SHALL have parameter DIV, 16-bit, default 16'h0145; baud divisor written to DLL/DLM.
REQ-002 SHALL have parameter LCR_VAL, 8-bit, default 8'h03 (8N1); line control value, bit7 must be 0.
REQ-003 SHALL have parameter FCR_VAL, 8-bit, default 8'h01; FIFO control value (enable).
REQ-004 SHALL have parameter TX_BURST, int, default 16; max THR writes per observed THRE, range 1..16.
REQ-005 SHALL have parameter POLL_GAP, int, default 4; idle cycles between LSR polls while THRE=0, range 0..255.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 s_valid  input  1  host byte available.
REQ-009 s_data  input  8  host byte.
REQ-010 s_ready  output  1  one-cycle accept pulse; byte consumed when s_valid and s_ready are both high.
REQ-011 wr  output  1  UART register write strobe.
REQ-012 rd  output  1  UART register read strobe.
REQ-013 addr  output  3  UART register address.
REQ-014 din  output  8  UART write data.
REQ-015 dout  input  8  UART read data, valid the cycle after rd.
REQ-016 init_done  output  1  high once the init sequence completes; stays high until reset.

Function
REQ-017 SHALL run the init FSM once after reset: W_LCR_DLAB (addr 3, LCR_VAL|8'h80) -> W_DLL (addr 0, DIV[7:0]) -> W_DLM (addr 1, DIV[15:8]) -> W_LCR (addr 3, LCR_VAL) -> W_FCR (addr 2, FCR_VAL|8'h06) -> IDLE; one wr pulse per state, one cycle each.
REQ-018 SHALL assert init_done on the first cycle in IDLE; s_ready SHALL stay low before then.
REQ-019 In IDLE with s_valid=1 and credit=0: RD_LSR (rd=1, addr 5) -> CAP_LSR (sample dout).
REQ-020 In CAP_LSR: dout[5]=1 loads credit=TX_BURST and goes to WR_THR; dout[5]=0 goes to GAP.
REQ-021 GAP SHALL count POLL_GAP cycles and then return to RD_LSR; POLL_GAP=0 returns on the next cycle.
REQ-022 WR_THR: if s_valid, assert wr=1, addr=0, din=s_data and s_ready=1 for one cycle, then decrement credit; otherwise go to IDLE.
REQ-023 After WR_THR: credit>0 and s_valid stays in WR_THR (back-to-back writes, 1 byte/cycle); credit==0 goes to IDLE, which forces a re-poll.
REQ-024 A drop of s_valid mid-burst SHALL preserve the remaining credit; an IDLE re-entry with credit>0 and s_valid goes straight to WR_THR without polling.
REQ-025 wr and rd SHALL never be high in the same cycle; addr/din SHALL be 0 when both are low.
REQ-026 The credit counter SHALL be 5 bits and SHALL saturate at 0.

Reset
REQ-027 rst low SHALL immediately force: state=W_LCR_DLAB pending, credit=0, gap=0, wr=rd=s_ready=init_done=0, addr=din=0.
REQ-028 Reset mid-burst or mid-init SHALL discard all progress; the full init sequence SHALL rerun after release.

Configuration
REQ-029 Macro UART_HOST_CTRL_RX_EN, when defined, SHALL add ports m_valid (output, 1), m_data (output, 8) and m_ready (input, 1), plus a one-entry RX holding register.
REQ-030 With the macro defined, every CAP_LSR with dout[0]=1 and an empty holding register SHALL insert RD_RBR (rd=1, addr 0) -> CAP_RBR (capture dout, m_valid=1) before the TX decision.
REQ-031 With the macro defined, IDLE with s_valid=0 and an empty holding register SHALL poll the LSR every POLL_GAP+2 cycles.
REQ-032 m_valid SHALL clear on m_valid&m_ready.
REQ-033 Without the macro, these ports and the RX logic SHALL be absent, and behaviour SHALL be exactly REQ-017..026.

Structure
REQ-034 Package uart_pkg SHALL hold the register address localparams (THR/RBR/DLL=0, IER/DLM=1, FCR=2, LCR=3, LSR=5), the LSR bit indices (DR=0, THRE=5) and the state enum type.
REQ-035 The block SHALL be a single module with no sub-modules.

Verification
REQ-036 Release reset with defaults -> wr pulses on 5 consecutive cycles: (3,83),(0,45),(1,01),(3,03),(2,07); init_done high on the next cycle.
REQ-037 s_valid=1, s_data=8'hA5, model LSR=8'h60 -> rd addr 5, then wr addr 0 din A5 with s_ready on the same cycle.
REQ-038 LSR=8'h00 for 3 polls then 8'h20, POLL_GAP=4 -> rd pulses 6 cycles apart; the byte is written after the 4th poll.
REQ-039 20 queued bytes, TX_BURST=16, LSR=8'h20 -> 16 back-to-back writes, one poll, then 4 writes.
REQ-040 Reset asserted during the 8th burst write -> outputs zero immediately; after release, init repeats and the byte is not double-accepted.
REQ-041 With UART_HOST_CTRL_RX_EN, LSR=8'h01, RBR=8'h3C, m_ready=0 -> m_valid=1, m_data=3C, no further RBR reads until m_ready=1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - 16550 register map, LSR bit positions and controller state encoding
package uart_pkg;

   localparam logic [2:0] REG_THR = 3'd0;
   localparam logic [2:0] REG_RBR = 3'd0;
   localparam logic [2:0] REG_DLL = 3'd0;
   localparam logic [2:0] REG_IER = 3'd1;
   localparam logic [2:0] REG_DLM = 3'd1;
   localparam logic [2:0] REG_FCR = 3'd2;
   localparam logic [2:0] REG_LCR = 3'd3;
   localparam logic [2:0] REG_LSR = 3'd5;

   localparam int LSR_DR   = 0;
   localparam int LSR_THRE = 5;

   typedef enum logic [3:0] {
      ST_W_LCR_DLAB,
      ST_W_DLL,
      ST_W_DLM,
      ST_W_LCR,
      ST_W_FCR,
      ST_IDLE,
      ST_RD_LSR,
      ST_CAP_LSR,
      ST_GAP,
      ST_WR_THR,
      ST_RD_RBR,
      ST_CAP_RBR
   } state_t;

endpackage

// File: rtl/uart_host_ctrl.sv
// rtl/uart_host_ctrl.sv - 16550 host controller: init sequence, LSR-polled TX bursts, optional RX path (UART_HOST_CTRL_RX_EN)
module uart_host_ctrl
   import uart_pkg::*;
#(
   parameter logic [15:0] DIV      = 16'h0145,
   parameter logic [7:0]  LCR_VAL  = 8'h03,
   parameter logic [7:0]  FCR_VAL  = 8'h01,
   parameter int          TX_BURST = 16,
   parameter int          POLL_GAP = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       wr,
   output logic       rd,
   output logic [2:0] addr,
   output logic [7:0] din,
   input  logic [7:0] dout,
`ifdef UART_HOST_CTRL_RX_EN
   output logic       m_valid,
   output logic [7:0] m_data,
   input  logic       m_ready,
`endif
   output logic       init_done
);

   localparam logic [4:0] BURST    = 5'(TX_BURST);
   localparam logic [8:0] GAP_LAST = (POLL_GAP == 0) ? 9'd0 : 9'(POLL_GAP - 1);

   state_t     state;
   logic [4:0] credit;
   logic [7:0] gap_cnt;
   logic       wr_q;
   logic       rd_q;
   logic [2:0] addr_q;
   logic [7:0] din_q;
   logic       thr_wr;
   logic       thre;

`ifdef UART_HOST_CTRL_RX_EN
   logic       rx_thre;
   logic [8:0] poll_cnt;
   // After an RBR detour the THRE seen in the preceding LSR read drives the TX decision.
   assign thre = (state == ST_CAP_RBR) ? rx_thre : dout[LSR_THRE];
`else
   assign thre = dout[LSR_THRE];
`endif

   // THR writes follow s_valid in the same cycle so a burst moves one byte per clock.
   assign thr_wr  = (state == ST_WR_THR) && s_valid;
   assign s_ready = thr_wr;
   assign wr      = wr_q | thr_wr;
   assign rd      = rd_q;
   assign addr    = thr_wr ? REG_THR : addr_q;
   assign din     = thr_wr ? s_data : din_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_W_LCR_DLAB;
         credit    <= '0;
         gap_cnt   <= '0;
         wr_q      <= 1'b0;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         init_done <= 1'b0;
`ifdef UART_HOST_CTRL_RX_EN
         rx_thre   <= 1'b0;
         poll_cnt  <= '0;
         m_valid   <= 1'b0;
         m_data    <= '0;
`endif
      end else begin
         wr_q   <= 1'b0;
         rd_q   <= 1'b0;
         addr_q <= '0;
         din_q  <= '0;
`ifdef UART_HOST_CTRL_RX_EN
         if (m_valid && m_ready) m_valid <= 1'b0;
         if (state == ST_RD_LSR) poll_cnt <= '0;
         else if (poll_cnt != '1) poll_cnt <= poll_cnt + 9'd1;
`endif
         case (state)
            ST_W_LCR_DLAB: begin
               wr_q   <= 1'b1;
               addr_q <= REG_LCR;
               din_q  <= LCR_VAL | 8'h80;
               state  <= ST_W_DLL;
            end
            ST_W_DLL: begin
               wr_q   <= 1'b1;
               addr_q <= REG_DLL;
               din_q  <= DIV[7:0];
               state  <= ST_W_DLM;
            end
            ST_W_DLM: begin
               wr_q   <= 1'b1;
               addr_q <= REG_DLM;
               din_q  <= DIV[15:8];
               state  <= ST_W_LCR;
            end
            ST_W_LCR: begin
               wr_q   <= 1'b1;
               addr_q <= REG_LCR;
               din_q  <= LCR_VAL;
               state  <= ST_W_FCR;
            end
            ST_W_FCR: begin
               wr_q   <= 1'b1;
               addr_q <= REG_FCR;
               din_q  <= FCR_VAL | 8'h06;
               state  <= ST_IDLE;
            end
            ST_IDLE: begin
               init_done <= 1'b1;
               if (s_valid && credit != '0) begin
                  state <= ST_WR_THR;
               end else if (s_valid) begin
                  rd_q   <= 1'b1;
                  addr_q <= REG_LSR;
                  state  <= ST_RD_LSR;
               end
`ifdef UART_HOST_CTRL_RX_EN
               else if (!m_valid && poll_cnt >= 9'(POLL_GAP)) begin
                  rd_q   <= 1'b1;
                  addr_q <= REG_LSR;
                  state  <= ST_RD_LSR;
               end
`endif
            end
            ST_RD_LSR, ST_RD_RBR: begin
               state <= (state == ST_RD_LSR) ? ST_CAP_LSR : ST_CAP_RBR;
            end
            ST_CAP_LSR, ST_CAP_RBR: begin
`ifdef UART_HOST_CTRL_RX_EN
               if (state == ST_CAP_RBR) begin
                  m_data  <= dout;
                  m_valid <= 1'b1;
               end
               if (state == ST_CAP_LSR && dout[LSR_DR] && !m_valid) begin
                  rx_thre <= dout[LSR_THRE];
                  rd_q    <= 1'b1;
                  addr_q  <= REG_RBR;
                  state   <= ST_RD_RBR;
               end else
`endif
               if (thre) begin
                  credit <= BURST;
                  state  <= ST_WR_THR;
               end else begin
                  gap_cnt <= '0;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if ({1'b0, gap_cnt} >= GAP_LAST) begin
                  rd_q   <= 1'b1;
                  addr_q <= REG_LSR;
                  state  <= ST_RD_LSR;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            ST_WR_THR: begin
               if (s_valid) begin
                  if (credit != '0) credit <= credit - 5'd1;
                  if (credit <= 5'd1) state <= ST_IDLE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_W_LCR_DLAB;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb/tb_uart_host_ctrl.sv - scoreboard bench for uart_host_ctrl with a behavioural 16550 register model
module tb_uart_host_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data = 8'h00;
   logic       s_ready;
   logic       wr;
   logic       rd;
   logic [2:0] addr;
   logic [7:0] din;
   logic [7:0] dout = 8'h00;
   logic       init_done;
`ifdef UART_HOST_CTRL_RX_EN
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready = 1'b0;
`endif

   always #5 clk = ~clk;

   uart_host_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_ready   (s_ready),
      .wr        (wr),
      .rd        (rd),
      .addr      (addr),
      .din       (din),
      .dout      (dout),
`ifdef UART_HOST_CTRL_RX_EN
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
`endif
      .init_done (init_done)
   );

   int cmp_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int inv_err = 0;
   int init_cyc = -1;

   logic [7:0]  host_q[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  lsr_q[$];
   logic [7:0]  lsr_default = 8'h20;
   logic [7:0]  rbr_val = 8'h3C;
   logic [10:0] wr_log[$];
   int          wr_cyc[$];
   logic [2:0]  rd_addr[$];
   int          rd_cyc[$];
   logic [7:0]  thr_log[$];
   int          thr_cyc[$];
   logic [10:0] init_seq[5];

   initial begin
      init_seq[0] = {3'd3, 8'h83};
      init_seq[1] = {3'd0, 8'h45};
      init_seq[2] = {3'd1, 8'h01};
      init_seq[3] = {3'd3, 8'h03};
      init_seq[4] = {3'd2, 8'h07};
   end

   // UART register model and host source, both acting mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (wr && rd) inv_err++;
         if (!wr && !rd && (addr !== 3'd0 || din !== 8'd0)) inv_err++;
         if (s_ready && !(wr && addr == 3'd0)) inv_err++;
         if (s_ready && !init_done) inv_err++;
         if (init_done && init_cyc < 0) init_cyc = cyc;
         if (wr) begin
            wr_log.push_back({addr, din});
            wr_cyc.push_back(cyc);
         end
         if (rd) begin
            rd_addr.push_back(addr);
            rd_cyc.push_back(cyc);
            if (addr == 3'd5) begin
               if (lsr_q.size() != 0) dout = lsr_q.pop_front();
               else dout = lsr_default;
            end else if (addr == 3'd0) begin
               dout = rbr_val;
            end
         end
         if (wr && addr == 3'd0 && s_ready) begin
            thr_log.push_back(din);
            thr_cyc.push_back(cyc);
         end
         if (s_valid && s_ready) void'(host_q.pop_front());
      end
      s_valid = (host_q.size() != 0);
      s_data  = s_valid ? host_q[0] : 8'h00;
   end

   task automatic clear_logs();
      wr_log.delete();
      wr_cyc.delete();
      rd_addr.delete();
      rd_cyc.delete();
      thr_log.delete();
      thr_cyc.delete();
      init_cyc = -1;
   endtask

   task automatic wait_init();
      int n = 0;
      while (init_cyc < 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (init_cyc < 0) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL init_timeout: init_done=%0b required 1", init_done);
      end
   endtask

   task automatic wait_thr(input int n);
      int k = 0;
      while (thr_log.size() < n && k < 600) begin
         @(posedge clk);
         k++;
      end
      #2;
      if (thr_log.size() < n) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL thr_timeout: writes=%0d required %0d", thr_log.size(), n);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      host_q.delete();
      exp_q.delete();
      lsr_q.delete();
      lsr_default = 8'h20;
      clear_logs();
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      wait_init();
   endtask

   task automatic push_byte(input logic [7:0] b);
      host_q.push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic test_reset();
      #12;
      cmp_cnt++;
      if ({wr, rd, s_ready, init_done, addr, din} !== 15'd0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got %h required 0", {wr, rd, s_ready, init_done, addr, din});
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      wait_init();
      cmp_cnt++;
      if (wr_log.size() != 5) begin
         err_cnt++;
         $display("FAIL init_count: got %0d required 5", wr_log.size());
      end
      for (int i = 0; i < 5; i++) begin
         cmp_cnt++;
         if (wr_log[i] !== init_seq[i] || wr_cyc[i] != wr_cyc[0] + i) begin
            err_cnt++;
            $display("FAIL init_write%0d: got %h@%0d required %h@%0d", i, wr_log[i], wr_cyc[i], init_seq[i], wr_cyc[0] + i);
         end
      end
      cmp_cnt++;
      if (init_cyc != wr_cyc[4] + 1) begin
         err_cnt++;
         $display("FAIL init_done_cycle: got %0d required %0d", init_cyc, wr_cyc[4] + 1);
      end
   endtask

   task automatic test_single();
      do_reset();
      lsr_q.push_back(8'h60);
      push_byte(8'hA5);
      wait_thr(1);
      cmp_cnt++;
      if (rd_addr.size() != 1 || rd_addr[0] !== 3'd5) begin
         err_cnt++;
         $display("FAIL single_poll: reads=%0d addr=%0d required 1 read at addr 5", rd_addr.size(), rd_addr[0]);
      end
      cmp_cnt++;
      if (thr_cyc[0] != rd_cyc[0] + 2) begin
         err_cnt++;
         $display("FAIL single_latency: got cycle %0d required %0d", thr_cyc[0], rd_cyc[0] + 2);
      end
      for (int i = 0; i < thr_log.size() && exp_q.size() != 0; i++) begin
         logic [7:0] e = exp_q.pop_front();
         cmp_cnt++;
         if (thr_log[i] !== e) begin
            err_cnt++;
            $display("FAIL single_data: got %h required %h", thr_log[i], e);
         end
      end
   endtask

   task automatic test_poll_gap();
      do_reset();
      lsr_q.push_back(8'h00);
      lsr_q.push_back(8'h00);
      lsr_q.push_back(8'h00);
      lsr_q.push_back(8'h20);
      push_byte(8'h5A);
      wait_thr(1);
      cmp_cnt++;
      if (rd_cyc.size() != 4) begin
         err_cnt++;
         $display("FAIL gap_polls: got %0d required 4", rd_cyc.size());
      end
      for (int i = 1; i < 4; i++) begin
         cmp_cnt++;
         if (rd_cyc[i] - rd_cyc[i-1] != 6) begin
            err_cnt++;
            $display("FAIL gap_spacing%0d: got %0d required 6", i, rd_cyc[i] - rd_cyc[i-1]);
         end
      end
      cmp_cnt++;
      if (thr_cyc[0] != rd_cyc[3] + 2 || thr_log[0] !== exp_q[0]) begin
         err_cnt++;
         $display("FAIL gap_write: got %h@%0d required %h@%0d", thr_log[0], thr_cyc[0], exp_q[0], rd_cyc[3] + 2);
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 20; i++) push_byte(8'($urandom));
      wait_thr(20);
      cmp_cnt++;
      if (rd_cyc.size() != 2 || rd_cyc[1] <= thr_cyc[15] || rd_cyc[1] >= thr_cyc[16]) begin
         err_cnt++;
         $display("FAIL burst_repoll: reads=%0d at %0d required 2 between %0d and %0d", rd_cyc.size(), rd_cyc[1], thr_cyc[15], thr_cyc[16]);
      end
      for (int i = 1; i < 20; i++) begin
         if (i != 16) begin
            cmp_cnt++;
            if (thr_cyc[i] != thr_cyc[i-1] + 1) begin
               err_cnt++;
               $display("FAIL burst_gap%0d: got cycle %0d required %0d", i, thr_cyc[i], thr_cyc[i-1] + 1);
            end
         end
      end
      for (int i = 0; i < thr_log.size() && exp_q.size() != 0; i++) begin
         logic [7:0] e = exp_q.pop_front();
         cmp_cnt++;
         if (thr_log[i] !== e) begin
            err_cnt++;
            $display("FAIL burst_data%0d: got %h required %h", i, thr_log[i], e);
         end
      end
   endtask

   task automatic test_credit_hold();
      do_reset();
      for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i));
      wait_thr(3);
      repeat (6) @(posedge clk);
      #2;
      push_byte(8'hC1);
      push_byte(8'hC2);
      wait_thr(5);
      cmp_cnt++;
      if (rd_cyc.size() != 1) begin
         err_cnt++;
         $display("FAIL hold_polls: got %0d required 1", rd_cyc.size());
      end
      for (int i = 0; i < thr_log.size() && exp_q.size() != 0; i++) begin
         logic [7:0] e = exp_q.pop_front();
         cmp_cnt++;
         if (thr_log[i] !== e) begin
            err_cnt++;
            $display("FAIL hold_data%0d: got %h required %h", i, thr_log[i], e);
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] bytes[12];
      int n = 0;
      do_reset();
      for (int i = 0; i < 12; i++) begin
         bytes[i] = 8'($urandom);
         push_byte(bytes[i]);
      end
      while (thr_log.size() < 7 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #2;
      cmp_cnt++;
      if (!(wr === 1'b1 && s_ready === 1'b1 && din === bytes[7])) begin
         err_cnt++;
         $display("FAIL mid_eighth_write: wr=%0b s_ready=%0b din=%h required 1 1 %h", wr, s_ready, din, bytes[7]);
      end
      rst = 1'b0;
      #1;
      cmp_cnt++;
      if ({wr, rd, s_ready, init_done, addr, din} !== 15'd0) begin
         err_cnt++;
         $display("FAIL mid_reset_outputs: got %h required 0", {wr, rd, s_ready, init_done, addr, din});
      end
      wr_log.delete();
      wr_cyc.delete();
      init_cyc = -1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      wait_init();
      for (int i = 0; i < 5; i++) begin
         cmp_cnt++;
         if (wr_log[i] !== init_seq[i]) begin
            err_cnt++;
            $display("FAIL reinit_write%0d: got %h required %h", i, wr_log[i], init_seq[i]);
         end
      end
      wait_thr(12);
      repeat (5) @(posedge clk);
      #2;
      cmp_cnt++;
      if (thr_log.size() != 12) begin
         err_cnt++;
         $display("FAIL mid_total_writes: got %0d required 12", thr_log.size());
      end
      for (int i = 0; i < thr_log.size() && exp_q.size() != 0; i++) begin
         logic [7:0] e = exp_q.pop_front();
         cmp_cnt++;
         if (thr_log[i] !== e) begin
            err_cnt++;
            $display("FAIL mid_data%0d: got %h required %h", i, thr_log[i], e);
         end
      end
   endtask

`ifdef UART_HOST_CTRL_RX_EN
   task automatic test_rx();
      int n = 0;
      int rbr_reads = 0;
      int last = 0;
      int prev = 0;
      do_reset();
      m_ready = 1'b0;
      lsr_default = 8'h01;
      rbr_val = 8'h3C;
      while (m_valid !== 1'b1 && n < 200) begin
         @(posedge clk);
         n++;
         #2;
      end
      cmp_cnt++;
      if (m_valid !== 1'b1 || m_data !== 8'h3C) begin
         err_cnt++;
         $display("FAIL rx_capture: m_valid=%0b m_data=%h required 1 3c", m_valid, m_data);
      end
      repeat (40) @(posedge clk);
      #2;
      foreach (rd_addr[i]) begin
         if (rd_addr[i] == 3'd0) rbr_reads++;
         else begin
            prev = last;
            last = rd_cyc[i];
         end
      end
      cmp_cnt++;
      if (rbr_reads != 1) begin
         err_cnt++;
         $display("FAIL rx_hold: rbr reads=%0d required 1", rbr_reads);
      end
      cmp_cnt++;
      if (last - prev != 6) begin
         err_cnt++;
         $display("FAIL rx_poll_period: got %0d required 6", last - prev);
      end
      m_ready = 1'b1;
      @(posedge clk);
      #2;
      m_ready = 1'b0;
      cmp_cnt++;
      if (m_valid !== 1'b0) begin
         err_cnt++;
         $display("FAIL rx_release: m_valid=%0b required 0", m_valid);
      end
      lsr_default = 8'h20;
   endtask
`endif

   task automatic test_invariants();
      cmp_cnt++;
      if (inv_err != 0) begin
         err_cnt++;
         $display("FAIL bus_invariants: violations=%0d required 0", inv_err);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_poll_gap();
      test_back_to_back();
      test_credit_hold();
      test_reset_mid_burst();
`ifdef UART_HOST_CTRL_RX_EN
      test_rx();
`endif
      test_invariants();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
